// File: rtl/hybrid_noc_router_be_out_buffer_if.sv
// Handshake bundle between the best-effort arbiter/mux side and the output link.
// The slave modport is the buffer; the master modport is the surrounding router logic.
interface hybrid_noc_router_be_out_buffer_if #(
   parameter int FLIT_WIDTH = 32,
   parameter int PORTS      = 5,
   parameter int DEPTH      = 4
);
   localparam int SW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [PORTS*FLIT_WIDTH-1:0] in_flit;
   logic [SW-1:0]               select;
   logic                        in_valid;
   logic                        in_last;
   logic                        in_ready;
   logic [FLIT_WIDTH-1:0]       out_flit;
   logic                        out_last;
   logic                        out_valid;
   logic                        out_ready;
   logic [CW-1:0]               count;

   modport slave (
      input  in_flit, select, in_valid, in_last, out_ready,
      output in_ready, out_flit, out_last, out_valid, count
   );

   modport master (
      output in_flit, select, in_valid, in_last, out_ready,
      input  in_ready, out_flit, out_last, out_valid, count
   );
endinterface

// File: rtl/hybrid_noc_router_be_out_buffer.sv
// Best-effort output stage: muxes the granted input flit into a DEPTH-entry FIFO.
// Optional packet gating is enabled by defining HYBRID_NOC_BE_OUTBUF_PKT_MODE_EN.
module hybrid_noc_router_be_out_buffer #(
   parameter int FLIT_WIDTH = 32,
   parameter int PORTS      = 5,
   parameter int DEPTH      = 4
) (
   input  logic clk,
   input  logic rst_n,
   hybrid_noc_router_be_out_buffer_if.slave bus
);
   localparam int SW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [FLIT_WIDTH:0]   r_mem [DEPTH];
   logic [AW-1:0]         r_wpt;
   logic [AW-1:0]         r_rpt;
   logic [CW-1:0]         r_count;
   logic [FLIT_WIDTH-1:0] w_sel_flit;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_sel_flit = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (bus.select == SW'(i)) w_sel_flit = bus.in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
      end
   end

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = bus.in_valid & bus.in_ready;
   assign w_pop   = bus.out_valid & bus.out_ready;

   // in_ready is held low while reset is asserted so nothing is lost during reset.
   assign bus.in_ready = rst_n & ~w_full;
   assign bus.count    = r_count;
   assign bus.out_flit = r_mem[r_rpt][FLIT_WIDTH-1:0];
   assign bus.out_last = r_mem[r_rpt][FLIT_WIDTH];

   // NOTE: the storage array has no reset; the pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wpt] <= {bus.in_last, w_sel_flit};
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wpt   <= '0;
         r_rpt   <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wpt <= r_wpt + AW'(1);
         if (w_pop)  r_rpt <= r_rpt + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef HYBRID_NOC_BE_OUTBUF_PKT_MODE_EN
   logic [CW-1:0] r_pkt_cnt;
   logic          w_push_last;
   logic          w_pop_last;

   assign w_push_last = w_push & bus.in_last;
   assign w_pop_last  = w_pop & bus.out_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_cnt <= '0;
      end else begin
         case ({w_push_last, w_pop_last})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + CW'(1);
            2'b01:   r_pkt_cnt <= r_pkt_cnt - CW'(1);
            default: r_pkt_cnt <= r_pkt_cnt;
         endcase
      end
   end

   // The full override lets packets longer than DEPTH stream out cut-through.
   assign bus.out_valid = ~w_empty & ((r_pkt_cnt != '0) | w_full);
`else
   assign bus.out_valid = ~w_empty;
`endif

endmodule

// File: tb/tb_hybrid_noc_router_be_out_buffer.sv
// Directed self-checking bench for hybrid_noc_router_be_out_buffer (FLIT_WIDTH=32, PORTS=5, DEPTH=4).
// Packet-mode steps are compiled in when HYBRID_NOC_BE_OUTBUF_PKT_MODE_EN is defined.
module tb_hybrid_noc_router_be_out_buffer;
   localparam int FW = 32;
   localparam int NP = 5;
   localparam int DP = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   hybrid_noc_router_be_out_buffer_if #(.FLIT_WIDTH(FW), .PORTS(NP), .DEPTH(DP)) bus ();

   hybrid_noc_router_be_out_buffer #(.FLIT_WIDTH(FW), .PORTS(NP), .DEPTH(DP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_flit(input logic [31:0] v, input int sel, input logic last);
      bus.in_flit = '0;
      bus.in_flit[sel*FW +: FW] = v;
      bus.select  = 3'(sel);
      bus.in_last = last;
   endtask

   initial begin
      int exp_v;
      int nxt;
      int sent;
      int got;
      bit seen_valid;
      bit popping;

      bus.in_flit   = '0;
      bus.select    = '0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;

      // Reset held for 3 cycles
      #1 rst_n = 1'b0;
      #1;
      check("rst_in_ready_held", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_count", 64'(bus.count), 64'd0);
      repeat (3) step();
      check("rst_in_ready_3cyc", 64'(bus.in_ready), 64'd0);
      check("rst_count_3cyc", 64'(bus.count), 64'd0);
      #3 rst_n = 1'b1;
      step();
      check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("post_rst_count", 64'(bus.count), 64'd0);

      // Mux: select 3 carries 0xDEADBEEF, single-flit packet
      drive_flit(32'hDEAD_BEEF, 3, 1'b1);
      bus.in_valid = 1'b1;
      #1;
      check("no_bypass_out_valid", 64'(bus.out_valid), 64'd0);
      step();
      bus.in_valid = 1'b0;
      bus.select   = 3'd0;
      check("mux_out_valid", 64'(bus.out_valid), 64'd1);
      check("mux_out_flit", 64'(bus.out_flit), 64'hDEAD_BEEF);
      check("mux_out_last", 64'(bus.out_last), 64'd1);
      check("mux_count", 64'(bus.count), 64'd1);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("mux_pop_count", 64'(bus.count), 64'd0);
      check("mux_pop_out_valid", 64'(bus.out_valid), 64'd0);

      // Fill with flits 1..4, out_ready held low
      for (int i = 1; i <= 4; i++) begin
         drive_flit(32'(i), i % NP, 1'b1);
         bus.in_valid = 1'b1;
         step();
      end
      check("fill_count", 64'(bus.count), 64'd4);
      check("fill_in_ready", 64'(bus.in_ready), 64'd0);
      drive_flit(32'd5, 0, 1'b1);
      step();
      check("fill_5th_rejected_count", 64'(bus.count), 64'd4);
      check("fill_head", 64'(bus.out_flit), 64'd1);
      check("fill_head_valid", 64'(bus.out_valid), 64'd1);

      // Full with in_valid and out_ready together: only the pop happens
      bus.out_ready = 1'b1;
      step();
      check("full_simul_count", 64'(bus.count), 64'd3);
      check("full_simul_in_ready", 64'(bus.in_ready), 64'd1);

      // Streaming: pushes 5..12 while popping, output order continues 2..12 with no gaps
      exp_v = 2;
      nxt   = 5;
      while (exp_v <= 12) begin
         if (nxt <= 12) begin
            drive_flit(32'(nxt), nxt % NP, 1'b1);
            bus.in_valid = 1'b1;
            check("stream_in_ready", 64'(bus.in_ready), 64'd1);
            check("stream_count", 64'(bus.count), 64'd3);
         end else begin
            bus.in_valid = 1'b0;
         end
         check("stream_out_valid", 64'(bus.out_valid), 64'd1);
         check("stream_out_flit", 64'(bus.out_flit), 64'(exp_v));
         check("stream_out_last", 64'(bus.out_last), 64'd1);
         step();
         if (nxt <= 12) nxt++;
         exp_v++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("stream_drained_count", 64'(bus.count), 64'd0);
      check("stream_drained_valid", 64'(bus.out_valid), 64'd0);

`ifdef HYBRID_NOC_BE_OUTBUF_PKT_MODE_EN
      // 3-flit packet: out_valid gated until the last flit is written
      for (int i = 0; i < 3; i++) begin
         drive_flit(32'h31 + 32'(i), i, i == 2);
         bus.in_valid = 1'b1;
         step();
         check("pkt3_out_valid", 64'(bus.out_valid), (i == 2) ? 64'd1 : 64'd0);
      end
      bus.in_valid = 1'b0;
      check("pkt3_count", 64'(bus.count), 64'd3);
      check("pkt3_head", 64'(bus.out_flit), 64'h31);
      bus.out_ready = 1'b1;
      repeat (3) step();
      bus.out_ready = 1'b0;
      check("pkt3_drained", 64'(bus.count), 64'd0);

      // 6-flit packet through a 4-deep FIFO: cut-through once full
      sent = 0;
      got = 0;
      seen_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         if (sent < 6) begin
            drive_flit(32'h60 + 32'(sent), sent % NP, sent == 5);
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         if (bus.out_valid && !seen_valid) begin
            seen_valid = 1'b1;
            check("pkt6_first_valid_count", 64'(bus.count), 64'd4);
         end
         popping = bus.out_valid & bus.out_ready;
         if (popping) begin
            check("pkt6_out_flit", 64'(bus.out_flit), 64'h60 + 64'(got));
            check("pkt6_out_last", 64'(bus.out_last), (got == 5) ? 64'd1 : 64'd0);
         end
         if (bus.in_valid && bus.in_ready) sent++;
         step();
         if (popping) got++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("pkt6_flits_received", 64'(got), 64'd6);
      check("pkt6_drained", 64'(bus.count), 64'd0);
`endif

      // Reset mid-packet: two flits of a 4-flit packet stored, then async reset pulse
      for (int i = 0; i < 2; i++) begin
         drive_flit(32'h71 + 32'(i), i, 1'b0);
         bus.in_valid = 1'b1;
         step();
      end
      bus.in_valid = 1'b0;
      check("midpkt_count", 64'(bus.count), 64'd2);
`ifdef HYBRID_NOC_BE_OUTBUF_PKT_MODE_EN
      check("midpkt_gated_valid", 64'(bus.out_valid), 64'd0);
`else
      check("midpkt_valid", 64'(bus.out_valid), 64'd1);
`endif
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_count", 64'(bus.count), 64'd0);
      check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("async_rst_in_ready", 64'(bus.in_ready), 64'd0);
      #2 rst_n = 1'b1;
      step();
      check("after_rst_in_ready", 64'(bus.in_ready), 64'd1);
      drive_flit(32'h0000_00A5, 1, 1'b1);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("fresh_out_valid", 64'(bus.out_valid), 64'd1);
      check("fresh_out_flit", 64'(bus.out_flit), 64'hA5);
      check("fresh_out_last", 64'(bus.out_last), 64'd1);
      check("fresh_count", 64'(bus.count), 64'd1);
`ifdef HYBRID_NOC_BE_OUTBUF_PKT_MODE_EN
      check("fresh_pkt_cnt", 64'(dut.r_pkt_cnt), 64'd1);
`endif
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("fresh_drained", 64'(bus.count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
